// File: rtl/bus_mux_pipe.sv
// Registered N-to-1 channel mux with a one-entry valid/ready output stage and a scan pointer.
// Optional out-of-range index flag (sel_err) enabled by defining BUS_MUX_PIPE_RANGE_CHK_EN.
module bus_mux_pipe #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 16,
   parameter int SEL_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    scan_en,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef BUS_MUX_PIPE_RANGE_CHK_EN
   ,
   output logic                    sel_err
`endif
);

   localparam int               LP_DEPTH = 1 << SEL_W;
   localparam logic [SEL_W-1:0] LP_LAST  = SEL_W'(NUM_IN - 1);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [WIDTH-1:0]  r_data;
   logic [SEL_W-1:0]  r_sel;
   logic [SEL_W-1:0]  r_scan_ptr;
   logic [SEL_W-1:0]  w_idx;
   logic [SEL_W-1:0]  w_ptr_next;
   logic              w_capture;
   logic [WIDTH-1:0]  w_chan [LP_DEPTH];

   // Pad the channel table to the full index range so out-of-range indices read zero.
   generate
      for (genvar gi = 0; gi < LP_DEPTH; gi++) begin : g_chan
         if (gi < NUM_IN) begin : g_live
            assign w_chan[gi] = in_bus[gi*WIDTH +: WIDTH];
         end else begin : g_pad
            assign w_chan[gi] = '0;
         end
      end
   endgenerate

   assign out_valid  = (r_state == ST_FULL);
   assign in_ready   = !out_valid || out_ready;
   assign w_capture  = in_valid && in_ready;
   assign w_idx      = scan_en ? r_scan_ptr : in_sel;
   assign w_ptr_next = (r_scan_ptr == LP_LAST) ? '0 : r_scan_ptr + 1'b1;
   assign out_data   = r_data;
   assign out_sel    = r_sel;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_capture) w_state_next = ST_FULL;
         ST_FULL: begin
            if (w_capture)      w_state_next = ST_FULL;
            else if (out_ready) w_state_next = ST_EMPTY;
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data     <= '0;
         r_sel      <= '0;
         r_scan_ptr <= '0;
      end else if (w_capture) begin
         r_data <= w_chan[w_idx];
         r_sel  <= w_idx;
         if (scan_en) r_scan_ptr <= w_ptr_next;
      end
   end

`ifdef BUS_MUX_PIPE_RANGE_CHK_EN
   localparam logic [SEL_W:0] LP_NUM = (SEL_W + 1)'(NUM_IN);

   logic r_err;
   logic w_oob;

   assign w_oob   = ({1'b0, w_idx} >= LP_NUM);
   assign sel_err = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_capture) begin
         r_err <= w_oob;
      end
   end
`endif

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Bench for bus_mux_pipe: a 16-channel and a 10-channel instance share stimulus; a queue-free
// behavioural model is checked every cycle, plus directed literal expectations.
module tb_bus_mux_pipe;

   logic           clk;
   logic           rst;
   logic [255:0]   bus;
   logic [3:0]     in_sel;
   logic           scan_en;
   logic           in_valid;
   logic           out_ready;
   logic           ir    [2];
   logic [15:0]    od    [2];
   logic [3:0]     osel  [2];
   logic           ov    [2];
`ifdef BUS_MUX_PIPE_RANGE_CHK_EN
   logic           oerr  [2];
`endif

   int errors = 0;
   int checks = 0;
   bit chk_on = 0;

   // Model state per instance (0: NUM_IN=16, 1: NUM_IN=10)
   bit         m_valid [2];
   int         m_data  [2];
   int         m_sel   [2];
   bit         m_err   [2];
   int         m_ptr   [2];
   int         nin     [2];

   bus_mux_pipe #(.WIDTH(16), .NUM_IN(16), .SEL_W(4)) dut_a (
      .clk(clk), .rst(rst), .in_bus(bus), .in_sel(in_sel), .scan_en(scan_en),
      .in_valid(in_valid), .in_ready(ir[0]), .out_data(od[0]), .out_sel(osel[0]),
      .out_valid(ov[0]), .out_ready(out_ready)
`ifdef BUS_MUX_PIPE_RANGE_CHK_EN
      , .sel_err(oerr[0])
`endif
   );

   bus_mux_pipe #(.WIDTH(16), .NUM_IN(10), .SEL_W(4)) dut_b (
      .clk(clk), .rst(rst), .in_bus(bus[159:0]), .in_sel(in_sel), .scan_en(scan_en),
      .in_valid(in_valid), .in_ready(ir[1]), .out_data(od[1]), .out_sel(osel[1]),
      .out_valid(ov[1]), .out_ready(out_ready)
`ifdef BUS_MUX_PIPE_RANGE_CHK_EN
      , .sel_err(oerr[1])
`endif
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h at %0t", name, act, $time);
      end
   endtask

   function automatic int eff_idx(int d);
      return scan_en ? m_ptr[d] : int'(in_sel);
   endfunction

   // Channel k of the bench's bus pattern is 0x1000+k; indices past NUM_IN read zero.
   function automatic int chan_val(int d, int idx);
      return (idx < nin[d]) ? (32'h1000 + idx) : 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_valid[d] <= 0;
            m_data[d]  <= 0;
            m_sel[d]   <= 0;
            m_err[d]   <= 0;
            m_ptr[d]   <= 0;
         end else if (in_valid && (!m_valid[d] || out_ready)) begin
            m_valid[d] <= 1;
            m_sel[d]   <= eff_idx(d);
            m_data[d]  <= chan_val(d, eff_idx(d));
            m_err[d]   <= (eff_idx(d) >= nin[d]);
            if (scan_en) m_ptr[d] <= (m_ptr[d] + 1) % nin[d];
         end else if (out_ready) begin
            m_valid[d] <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("mdl%0d_valid", d), 32'(ov[d]), 32'(m_valid[d]));
            check($sformatf("mdl%0d_ready", d), 32'(ir[d]), 32'(!m_valid[d] || out_ready));
            if (m_valid[d]) begin
               check($sformatf("mdl%0d_data", d), 32'(od[d]), 32'(m_data[d]));
               check($sformatf("mdl%0d_sel", d), 32'(osel[d]), 32'(m_sel[d]));
`ifdef BUS_MUX_PIPE_RANGE_CHK_EN
               check($sformatf("mdl%0d_err", d), 32'(oerr[d]), 32'(m_err[d]));
`endif
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nin[0] = 16;
      nin[1] = 10;
      for (int k = 0; k < 16; k++) bus[k*16 +: 16] = 16'h1000 + 16'(k);
      rst = 1; in_sel = 0; scan_en = 0; in_valid = 0; out_ready = 0;
      #1;
      check("rst_valid", 32'(ov[0]), 0);
      check("rst_data", 32'(od[0]), 0);
      check("rst_ready", 32'(ir[0]), 1);
      @(posedge clk);
      @(posedge clk);
      in_sel = 5; in_valid = 1; out_ready = 1;
      #3 rst = 0;
      chk_on = 1;

      // first edge after release captures channel 5
      step();
      check("sel5_data", 32'(od[0]), 32'h1005);
      check("sel5_sel", 32'(osel[0]), 5);
      check("sel5_valid", 32'(ov[0]), 1);

      // stall holds word while in_sel moves
      in_sel = 3;
      step();
      check("sel3_data", 32'(od[0]), 32'h1003);
      out_ready = 0; in_sel = 9;
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_data", 32'(od[0]), 32'h1003);
         check("stall_ready", 32'(ir[0]), 0);
      end
      out_ready = 1;
      step();
      check("unstall_data", 32'(od[0]), 32'h1009);

      // drain to empty, then scan 18 words back to back
      in_valid = 0;
      step();
      check("drain_valid", 32'(ov[0]), 0);
      scan_en = 1; in_valid = 1;
      for (int i = 0; i < 18; i++) begin
         step();
         check("scan_sel", 32'(osel[0]), 32'(i % 16));
         check("scan_valid", 32'(ov[0]), 1);
         check("scan_b_sel", 32'(osel[1]), 32'(i % 10));
      end

      // out-of-range indices on the 10-channel instance
      scan_en = 0;
      in_sel = 10;
      step();
      check("oob10_data", 32'(od[1]), 0);
      in_sel = 12;
      step();
      check("oob12_data", 32'(od[1]), 0);
      check("oob12_a_data", 32'(od[0]), 32'h100c);
`ifdef BUS_MUX_PIPE_RANGE_CHK_EN
      check("oob12_err", 32'(oerr[1]), 1);
`endif
      in_sel = 15;
      step();
      check("oob15_data", 32'(od[1]), 0);
      in_sel = 2;
      step();
      check("sel2_b_data", 32'(od[1]), 32'h1002);
`ifdef BUS_MUX_PIPE_RANGE_CHK_EN
      check("sel2_err", 32'(oerr[1]), 0);
`endif

      // asynchronous reset while full and stalled
      in_sel = 7;
      step();
      out_ready = 0;
      step();
      check("prerst_valid", 32'(ov[0]), 1);
      #3 rst = 1;
      #1;
      check("arst_valid", 32'(ov[0]), 0);
      check("arst_data", 32'(od[0]), 0);
      check("arst_ready", 32'(ir[0]), 1);
      scan_en = 1; in_valid = 1; out_ready = 1;
      step();
      check("rst_edge_nocap", 32'(ov[0]), 0);
      #2 rst = 0;
      step();
      check("post_rst_sel", 32'(osel[0]), 0);
      check("post_rst_data", 32'(od[0]), 32'h1000);
      step();
      check("post_rst_sel1", 32'(osel[0]), 1);
      in_valid = 0;
      step();
      step();
      chk_on = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
